// File: rtl/bcd7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bcd7_display_ctrl
// Purpose  : Memory-mapped 4-digit seven-segment display controller. The
//            CPU writes VALUE/CTRL/RAW registers; the block time-multiplexes
//            four hex digits onto a single anode/segment bus.
// Ports    : clk      - system clock, rising edge
//            reset    - asynchronous active-high reset
//            wr_en    - bus write strobe (single cycle)
//            addr     - bus byte address (word decode on addr[31:2])
//            wr_data  - bus write data
//            rd_en    - bus read strobe
//            rd_data  - combinational read data, 0 when not selected
//            BCD7     - [11:8] one-hot digit enable, [7] DP, [6:0] seg g..a
// Options  : define BCD7_LEADING_ZERO_BLANK_EN to blank leading zero digits
//            (digit0 is never blanked).
// Revision : 1.0 - initial release
// ============================================================================
module bcd7_display_ctrl #(
    parameter logic [31:0] BASE_ADDR = 32'h4000_0010,
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned CNT_W     = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        rd_en,
    output logic [31:0] rd_data,
    output logic [11:0] BCD7
);

    localparam logic [29:0]      C_VALUE_WORD = BASE_ADDR[31:2];
    localparam logic [29:0]      C_CTRL_WORD  = BASE_ADDR[31:2] + 30'd1;
    localparam logic [29:0]      C_RAW_WORD   = BASE_ADDR[31:2] + 30'd2;
    localparam logic [CNT_W-1:0] C_CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);

    logic [15:0]      value_q, value_d;
    logic [5:0]       ctrl_q, ctrl_d;        // [0] EN, [1] RAW, [5:2] DP mask
    logic [11:0]      raw_q, raw_d;
    logic [CNT_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [11:0]      bcd7_q, bcd7_d;

    logic       w_sel_value;
    logic       w_sel_ctrl;
    logic       w_sel_raw;
    logic       w_scan_run;
    logic [3:0] w_nibble;
    logic [6:0] w_seg;
    logic [3:0] w_anode;
    logic [3:0] w_dp_mask;
    logic       w_dp;
    logic       w_unused_bits;

    // Byte lanes and upper data bits have no storage behind them.
    assign w_unused_bits = ^{addr[1:0], wr_data[31:16]};

    assign w_sel_value = (addr[31:2] == C_VALUE_WORD);
    assign w_sel_ctrl  = (addr[31:2] == C_CTRL_WORD);
    assign w_sel_raw   = (addr[31:2] == C_RAW_WORD);

    // Segment patterns, g..a, active-high.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    // Register file writes.
    always_comb begin
        value_d = value_q;
        ctrl_d  = ctrl_q;
        raw_d   = raw_q;
        if (wr_en) begin
            if (w_sel_value) value_d = wr_data[15:0];
            if (w_sel_ctrl)  ctrl_d  = wr_data[5:0];
            if (w_sel_raw)   raw_d   = wr_data[11:0];
        end
    end

    // Reads return the pre-write contents when a write hits the same cycle.
    always_comb begin
        rd_data = 32'h0;
        if (rd_en) begin
            if (w_sel_value)     rd_data = {16'h0, value_q};
            else if (w_sel_ctrl) rd_data = {26'h0, ctrl_q};
            else if (w_sel_raw)  rd_data = {20'h0, raw_q};
        end
    end

    // Scan runs only in normal display mode; otherwise it is parked at
    // digit0 so re-enabling always starts from the least significant digit.
    assign w_scan_run = ctrl_q[0] & ~ctrl_q[1];

    always_comb begin
        scan_cnt_d  = '0;
        digit_idx_d = 2'd0;
        if (w_scan_run) begin
            if (scan_cnt_q == C_CNT_LAST) begin
                scan_cnt_d  = '0;
                digit_idx_d = digit_idx_q + 2'd1;
            end else begin
                scan_cnt_d  = scan_cnt_q + C_CNT_ONE;
                digit_idx_d = digit_idx_q;
            end
        end
    end

    always_comb begin
        case (digit_idx_q)
            2'd0:    w_nibble = value_q[3:0];
            2'd1:    w_nibble = value_q[7:4];
            2'd2:    w_nibble = value_q[11:8];
            default: w_nibble = value_q[15:12];
        endcase
    end

`ifdef BCD7_LEADING_ZERO_BLANK_EN
    logic w_blank;

    // A digit is blank when it and every more significant nibble are zero.
    always_comb begin
        case (digit_idx_q)
            2'd1:    w_blank = (value_q[15:4] == 12'h000);
            2'd2:    w_blank = (value_q[15:8] == 8'h00);
            2'd3:    w_blank = (value_q[15:12] == 4'h0);
            default: w_blank = 1'b0;
        endcase
    end

    assign w_seg = w_blank ? 7'h00 : seg_decode(w_nibble);
`else
    assign w_seg = seg_decode(w_nibble);
`endif

    assign w_anode   = 4'b0001 << digit_idx_q;
    assign w_dp_mask = ctrl_q[5:2];
    assign w_dp      = w_dp_mask[digit_idx_q];

    // RAW mode takes priority over the enable bit.
    always_comb begin
        if (ctrl_q[1]) begin
            bcd7_d = raw_q;
        end else if (!ctrl_q[0]) begin
            bcd7_d = 12'h000;
        end else begin
            bcd7_d = {w_anode, w_dp, w_seg};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            value_q     <= 16'h0;
            ctrl_q      <= 6'h01;
            raw_q       <= 12'h0;
            scan_cnt_q  <= '0;
            digit_idx_q <= 2'd0;
            bcd7_q      <= 12'h0;
        end else begin
            value_q     <= value_d;
            ctrl_q      <= ctrl_d;
            raw_q       <= raw_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_idx_q <= digit_idx_d;
            bcd7_q      <= bcd7_d;
        end
    end

    assign BCD7 = bcd7_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd7_display_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bcd7_display_ctrl
// Purpose  : Scoreboard bench for bcd7_display_ctrl. Stimulus pushes
//            expected BCD7 values tagged with the cycle they must appear on,
//            and expected read data for each read strobe; a monitor on the
//            falling edge pops and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bcd7_display_ctrl;

    localparam logic [31:0] BASE = 32'h4000_0010;

`ifdef BCD7_LEADING_ZERO_BLANK_EN
    localparam logic [11:0] Z1 = 12'h200;
    localparam logic [11:0] Z2 = 12'h400;
    localparam logic [11:0] Z3 = 12'h800;
`else
    localparam logic [11:0] Z1 = 12'h23F;
    localparam logic [11:0] Z2 = 12'h43F;
    localparam logic [11:0] Z3 = 12'h83F;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [11:0] BCD7;

    bcd7_display_ctrl #(
        .BASE_ADDR (BASE),
        .SCAN_DIV  (4),
        .CNT_W     (3)
    ) u_dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .addr    (addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .BCD7    (BCD7)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [31:0] cyc;
        logic [11:0] val;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          checks  = 0;
    int          errors  = 0;
    logic        done    = 1'b0;
    logic        drained = 1'b0;

    // Monitor: compares BCD7 against every entry due this cycle and rd_data
    // whenever a read strobe is presented.
    always @(negedge clk) begin : mon
        exp_t        e;
        logic [31:0] r;
        while (exp_q.size() > 0 && int'(exp_q[0].cyc) <= cyc) begin
            e = exp_q.pop_front();
            checks++;
            if (int'(e.cyc) != cyc || BCD7 !== e.val) begin
                errors++;
                $display("FAIL bcd7 cycle %0d: got %03h expected %03h (due cycle %0d)",
                         cyc, BCD7, e.val, e.cyc);
            end
        end
        if (rd_en) begin
            checks++;
            if (rd_q.size() == 0) begin
                errors++;
                $display("FAIL rd_data cycle %0d: got %08h with no read expected", cyc, rd_data);
            end else begin
                r = rd_q.pop_front();
                if (rd_data !== r) begin
                    errors++;
                    $display("FAIL rd_data cycle %0d addr %08h: got %08h expected %08h",
                             cyc, addr, rd_data, r);
                end
            end
        end
        if (done && !drained) begin
            checks++;
            if (exp_q.size() != 0 || rd_q.size() != 0) begin
                errors++;
                $display("FAIL scoreboard drain: got %0d bcd7 and %0d read entries left, expected 0",
                         exp_q.size(), rd_q.size());
            end
            drained <= 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) tick();
    endtask

    task automatic push(input int from, input int to, input logic [11:0] v);
        exp_t e;
        for (int c = from; c <= to; c++) begin
            e.cyc = 32'(c);
            e.val = v;
            exp_q.push_back(e);
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] expv);
        addr  = a;
        rd_en = 1'b1;
        rd_q.push_back(expv);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic wr_rd(input logic [31:0] a, input logic [31:0] d, input logic [31:0] expv);
        addr    = a;
        wr_data = d;
        wr_en   = 1'b1;
        rd_en   = 1'b1;
        rd_q.push_back(expv);
        tick();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
    endtask

    // Park the scan, load VALUE, then enable with CTRL=c and expect one
    // full rotation of four digits (4 cycles each) plus the wrap to digit0.
    task automatic run_scan(input logic [15:0] v, input logic [5:0] c,
                            input logic [11:0] d0, input logic [11:0] d1,
                            input logic [11:0] d2, input logic [11:0] d3);
        int s;
        wr(BASE + 32'd4, 32'h0);
        wr(BASE, {16'h0, v});
        s = cyc;
        push(s + 1,  s + 1,  12'h000);
        push(s + 2,  s + 5,  d0);
        push(s + 6,  s + 9,  d1);
        push(s + 10, s + 13, d2);
        push(s + 14, s + 17, d3);
        push(s + 18, s + 18, d0);
        wr(BASE + 32'd4, {26'h0, c});
        wait_cyc(s + 18);
    endtask

    initial begin : stim
        int r0;
        int q;
        int s;
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = 32'h0;
        wr_data = 32'h0;

        // Reset state
        push(1, 3, 12'h000);
        tick();
        rd(BASE,          32'h0);
        rd(BASE + 32'd4,  32'h1);
        rd(BASE + 32'd8,  32'h0);

        // Scan of 0x1234 from reset release
        r0 = cyc;
        reset = 1'b0;
        push(r0 + 1,  r0 + 1,  12'h13F);
        push(r0 + 2,  r0 + 4,  12'h166);
        push(r0 + 5,  r0 + 8,  12'h24F);
        push(r0 + 9,  r0 + 12, 12'h45B);
        push(r0 + 13, r0 + 16, 12'h806);
        push(r0 + 17, r0 + 20, 12'h166);
        wr(BASE, 32'h0000_1234);
        wait_cyc(r0 + 20);

        // RAW mode, then back to scan at digit0
        push(r0 + 21, r0 + 22, 12'h24F);
        wr(BASE + 32'd8, 32'h0000_0ABC);
        q = cyc;
        push(q + 2, q + 6, 12'hABC);
        wr(BASE + 32'd4, 32'h3);
        rd(BASE + 32'd4, 32'h3);
        rd(BASE + 32'd8, 32'hABC);
        wait_cyc(q + 6);
        s = cyc;
        push(s + 1, s + 1, 12'hABC);
        push(s + 2, s + 5, 12'h166);
        push(s + 6, s + 9, 12'h24F);
        wr(BASE + 32'd4, 32'h1);
        wait_cyc(s + 9);

        // Disable mid-scan at digit2, re-enable restarts at digit0
        s = cyc;
        push(s + 1, s + 2, 12'h45B);
        push(s + 3, s + 5, 12'h000);
        tick();
        wr(BASE + 32'd4, 32'h0);
        wait_cyc(s + 5);
        s = cyc;
        push(s + 1, s + 1, 12'h000);
        push(s + 2, s + 5, 12'h166);
        push(s + 6, s + 9, 12'h24F);
        wr(BASE + 32'd4, 32'h1);
        wait_cyc(s + 9);

        // Digit patterns, DP masks and leading-zero handling
        run_scan(16'h0005, 6'h05, 12'h1ED, Z1,      Z2,      Z3);
        run_scan(16'h0030, 6'h01, 12'h13F, 12'h24F, Z2,      Z3);
        run_scan(16'hBE70, 6'h29, 12'h13F, 12'h287, 12'h479, 12'h8FC);
        run_scan(16'hD6A8, 6'h01, 12'h17F, 12'h277, 12'h47D, 12'h85E);
        run_scan(16'h00C9, 6'h01, 12'h16F, 12'h239, Z2,      Z3);

        // Readback, unused bits, unmapped address, byte-offset decode
        wr(BASE, 32'hDEAD_BEEF);
        rd(BASE, 32'h0000_BEEF);
        wr(BASE + 32'd8, 32'hFFFF_F5A5);
        rd(BASE + 32'd8, 32'h0000_05A5);
        wr(BASE + 32'd4, 32'hFFFF_FFC2);
        rd(BASE + 32'd4, 32'h0000_0002);
        s = cyc;
        push(s + 1, s + 10, 12'h5A5);
        rd(BASE + 32'd12, 32'h0);
        wr(BASE + 32'd12, 32'h0000_0001);
        rd(BASE,          32'h0000_BEEF);
        rd(BASE + 32'd4,  32'h0000_0002);
        rd(BASE + 32'd8,  32'h0000_05A5);
        wr(BASE + 32'd1, 32'h0000_0777);
        rd(BASE,          32'h0000_0777);
        rd(BASE + 32'd3,  32'h0000_0777);
        wr_rd(BASE, 32'h0000_1111, 32'h0000_0777);
        rd(BASE,          32'h0000_1111);

        // Asynchronous reset during digit3
        wr(BASE + 32'd4, 32'h0);
        wr(BASE, 32'h0000_FFFF);
        s = cyc;
        push(s + 1,  s + 1,  12'h000);
        push(s + 2,  s + 5,  12'h171);
        push(s + 6,  s + 6,  12'h271);
        push(s + 14, s + 14, 12'h871);
        push(s + 15, s + 16, 12'h000);
        push(s + 17, s + 18, 12'h13F);
        wr(BASE + 32'd4, 32'h1);
        wait_cyc(s + 15);
        reset = 1'b1;
        rd(BASE, 32'h0);
        reset = 1'b0;
        rd(BASE,         32'h0);
        rd(BASE + 32'd4, 32'h1);
        wait_cyc(s + 19);

        done = 1'b1;
        for (int i = 0; i < 10 && !drained; i++) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/bcd7_display_ctrl.md
Name: bcd7_display_ctrl

Overview:
Memory-mapped 4-digit seven-segment display controller. It sits on the CPU data-memory bus, directly downstream of the CPU core, and drives the top-level `BCD7` output.
- CPU stores to three peripheral registers.
- Block time-multiplexes four hex digits onto one 12-bit anode/segment bus with a programmable scan divider.

Parameters:
- BASE_ADDR, 32'h4000_0010, byte address of the VALUE register; CTRL = BASE+4, RAW = BASE+8.
- SCAN_DIV, 100000, clock cycles each digit stays lit (≥2); benches use 4.
- CNT_W, 17, scan counter width; must satisfy 2^CNT_W ≥ SCAN_DIV.

Ports:
- clk      in   1   system clock, rising edge
- reset    in   1   asynchronous, active-high reset
- wr_en    in   1   bus write strobe, single cycle
- addr     in   32  bus byte address, shared by read and write
- wr_data  in   32  write data
- rd_en    in   1   bus read strobe
- rd_data  out  32  read data, combinational; 0 when not selected
- BCD7     out  12  [11:8] one-hot digit enable (active-high, bit8 = digit0 = least significant); [7] decimal point; [6:0] segments g..a, active-high

Behaviour:
- Register map, word access only; address compare on addr[31:2], addr[1:0] ignored; other addresses ignored, no side effects.
  - VALUE: bits[15:0] hold four hex nibbles; digit k = VALUE[4k+3:4k].
  - CTRL: bit0 EN, bit1 RAW, bits[5:2] DP mask (bit 2+k lights DP on digit k).
  - RAW: bits[11:0] hold a direct BCD7 pattern.
  - Unused bits read as 0.
- Reset values (async, immediate):
  - VALUE=0, CTRL=32'h1 (EN=1), RAW=0.
  - scan_cnt=0, digit_idx=0.
  - BCD7=0.
- Scan counter:
  - When EN=1 and RAW=0, scan_cnt increments each cycle.
  - At SCAN_DIV-1, scan_cnt wraps to 0 and digit_idx increments mod 4 (3 wraps to 0).
  - When EN=0 or RAW=1, scan_cnt and digit_idx are cleared to 0 and held.
- Output register: BCD7 is registered and updated every cycle from the current register contents and digit_idx.
  - EN=0 → 12'h000.
  - RAW=1 (RAW overrides EN) → RAW[11:0].
  - Otherwise → {onehot(digit_idx), DP[digit_idx], seg(nibble)}.
- Segment table (g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
- Latency: a write accepted at edge N is visible on BCD7 after edge N+1. A digit advance at edge N is visible after edge N+1.
- Simultaneous events:
  - Write and digit advance in the same cycle → both take effect; the next BCD7 uses the new digit with the new data.
  - A write to CTRL clearing EN mid-scan restarts the scan at digit0 once EN is set again.
  - wr_en and rd_en in the same cycle → rd_data returns the old value.
- Reset asserted mid-scan → all state returns to reset values asynchronously; scan resumes at digit0 after release.

Optional Feature:
- Macro: BCD7_LEADING_ZERO_BLANK_EN.
- Defined: in scan mode, a digit k ≥ 1 whose nibble and all higher nibbles are zero outputs segments 7'h00. Its anode bit is still driven and its DP is still honoured. Digit0 is never blanked.
- Undefined: all four digits always show their nibble.

Test Plan:
1. Reset, SCAN_DIV=4, write VALUE=0x1234 → BCD7 cycles 12'h166, 12'h24F, 12'h45B, 12'h806, each held 4 cycles, then wraps to 12'h166.
2. Write CTRL=0x3 with RAW=0xABC → BCD7=12'hABC from the second edge after the CTRL write. Write CTRL=0x1 → scan resumes at digit0 (12'h166 with VALUE=0x1234).
3. Write CTRL=0x0 mid-scan at digit2 → BCD7=12'h000 next cycle. Write CTRL=0x1 → first digit shown is digit0.
4. VALUE=0x0005, CTRL=0x5 (DP on digit0), macro defined → BCD7 sequence 12'h1ED, 12'h200, 12'h400, 12'h800. Macro undefined → 12'h1ED, 12'h23F, 12'h43F, 12'h83F.
5. Readback and decode:
   - Read VALUE/CTRL/RAW → written values with unused bits 0.
   - Read BASE+12 → rd_data=0.
   - Write to BASE+12 → no register change.
   - Write at BASE+1 → decoded as VALUE.
6. Assert reset during digit3 with VALUE=0xFFFF → BCD7=0 immediately, before the next clock edge. After release, VALUE reads 0 and BCD7=12'h13F.
